// File: rtl/mmio_timer_irq.sv
// Memory-mapped countdown timer with prescaler and level-held active-low IRQ.
// Reads are combinational and zero when unselected; writes commit on the clock edge.
module mmio_timer_irq #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memaddr,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  be,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        nIRQ
);

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_LOAD     = 3'd1;
  localparam logic [2:0] IDX_COUNT    = 3'd2;
  localparam logic [2:0] IDX_STATUS   = 3'd3;
  localparam logic [2:0] IDX_PRESCALE = 3'd4;

  logic                  r_en;
  logic                  r_auto;
  logic                  r_ie;
  logic                  r_pend;
  logic                  r_nirq;
  logic [31:0]           r_load;
  logic [31:0]           r_count;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pcnt;

  logic                  w_sel;
  logic [2:0]            w_idx;
  logic                  w_wr;
  logic [31:0]           w_mask;
  logic [31:0]           w_load_merged;
  logic [31:0]           w_count_merged;
  logic [PRESCALE_W-1:0] w_prescale_merged;
  logic                  w_tick;
  logic                  w_expire;
  logic                  w_ctrl_wr;
  logic                  w_pend_clr;
  logic                  w_unused;

  assign w_sel    = (memaddr[31:5] == BASE_ADDR[31:5]);
  assign w_idx    = memaddr[4:2];
  // A write with no byte lanes enabled is not a write at all, so the timer keeps running.
  assign w_wr     = w_sel & memwrite & (|be);
  assign w_unused = ^memaddr[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_mask[8*gi +: 8] = {8{be[gi]}};
    end
  endgenerate

  assign w_load_merged     = (r_load & ~w_mask) | (writedata & w_mask);
  assign w_count_merged    = (r_count & ~w_mask) | (writedata & w_mask);
  assign w_prescale_merged = (r_prescale & ~w_mask[PRESCALE_W-1:0])
                           | (writedata[PRESCALE_W-1:0] & w_mask[PRESCALE_W-1:0]);

  assign w_tick     = r_en & (r_pcnt == r_prescale);
  assign w_expire   = w_tick & (r_count == 32'd0);
  assign w_ctrl_wr  = w_wr & (w_idx == IDX_CTRL) & be[0];
  assign w_pend_clr = w_wr & (w_idx == IDX_STATUS) & be[0] & writedata[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en       <= 1'b0;
      r_auto     <= 1'b0;
      r_ie       <= 1'b0;
      r_pend     <= 1'b0;
      r_nirq     <= 1'b1;
      r_load     <= 32'd0;
      r_count    <= 32'd0;
      r_prescale <= '0;
      r_pcnt     <= '0;
    end else begin
      r_nirq <= ~(r_pend & r_ie);

      // Software control of EN takes priority over one-shot auto-disable.
      if (w_ctrl_wr) begin
        r_en   <= writedata[0];
        r_auto <= writedata[1];
        r_ie   <= writedata[2];
      end else if (w_expire && !r_auto) begin
        r_en <= 1'b0;
      end

      // Held at zero while disabled, so a 0->1 EN transition always starts a fresh period.
      if (!r_en || w_tick) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + PRESCALE_W'(1);
      end

      if (w_wr && (w_idx == IDX_COUNT)) begin
        r_count <= w_count_merged;
      end else if (w_tick) begin
        if (r_count != 32'd0) begin
          r_count <= r_count - 32'd1;
        end else if (r_auto) begin
          r_count <= r_load;
        end
      end

      if (w_wr && (w_idx == IDX_LOAD)) begin
        r_load <= w_load_merged;
      end

      if (w_wr && (w_idx == IDX_PRESCALE)) begin
        r_prescale <= w_prescale_merged;
      end

      if (w_expire) begin
        r_pend <= 1'b1;
      end else if (w_pend_clr) begin
        r_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    readdata = 32'd0;
    if (w_sel && memread) begin
      case (w_idx)
        IDX_CTRL:     readdata = {29'd0, r_ie, r_auto, r_en};
        IDX_LOAD:     readdata = r_load;
        IDX_COUNT:    readdata = r_count;
        IDX_STATUS:   readdata = {31'd0, r_pend};
        IDX_PRESCALE: readdata = {{(32-PRESCALE_W){1'b0}}, r_prescale};
        default:      readdata = 32'd0;
      endcase
    end
  end

  assign nIRQ = r_nirq;

endmodule

// File: tb/tb_mmio_timer_irq.sv
// Scoreboard bench for mmio_timer_irq: a register-level reference model predicts
// readdata and nIRQ for every cycle; a separate monitor pops and compares.
module tb_mmio_timer_irq;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] memaddr = 32'd0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [3:0]  be = 4'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        nIRQ;

  mmio_timer_irq #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clk(clk), .reset(reset), .memaddr(memaddr), .memwrite(memwrite),
    .memread(memread), .be(be), .writedata(writedata),
    .readdata(readdata), .nIRQ(nIRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    bit          ar;
    bit          ie;
    bit          pend;
    bit [31:0]   load;
    bit [31:0]   count;
    bit [15:0]   pre;
    bit [15:0]   pcnt;
    bit          nirq;
  } m_t;

  typedef struct {
    logic [31:0] rd;
    logic        nirq;
    string       tag;
  } exp_t;

  exp_t q[$];
  m_t   m;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;

  function automatic m_t model_reset();
    m_t s;
    s = '{default: 0};
    s.nirq = 1'b1;
    return s;
  endfunction

  function automatic bit [31:0] merge(bit [31:0] old, bit [31:0] wd, bit [3:0] b);
    bit [31:0] r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(m_t s, logic [31:0] a, logic rd);
    logic [31:0] v = 32'd0;
    if (rd && a[31:5] == BASE[31:5]) begin
      case (a[4:2])
        3'd0: v = {29'd0, s.ie, s.ar, s.en};
        3'd1: v = s.load;
        3'd2: v = s.count;
        3'd3: v = {31'd0, s.pend};
        3'd4: v = {16'd0, s.pre};
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  // One clock edge: first the timer evolves by its own rules, then bus writes override.
  function automatic m_t model_step(m_t s, logic rst, logic [31:0] a, logic wr,
                                    logic [3:0] b, logic [31:0] wd);
    m_t  n;
    bit  tick, expire, bw;
    if (rst) return model_reset();
    n      = s;
    tick   = s.en && (s.pcnt == s.pre);
    expire = tick && (s.count == 0);
    bw     = wr && (a[31:5] == BASE[31:5]) && (b != 4'd0);
    n.nirq = !(s.pend && s.ie);
    n.pcnt = (s.en && !tick) ? s.pcnt + 16'd1 : 16'd0;
    if (tick) begin
      if (s.count != 0) n.count = s.count - 1;
      else begin
        n.pend = 1'b1;
        if (s.ar) n.count = s.load;
        else      n.en = 1'b0;
      end
    end
    if (bw) begin
      case (a[4:2])
        3'd0: if (b[0]) begin n.en = wd[0]; n.ar = wd[1]; n.ie = wd[2]; end
        3'd1: n.load  = merge(s.load, wd, b);
        3'd2: n.count = merge(s.count, wd, b);
        3'd3: if (b[0] && wd[0] && !expire) n.pend = 1'b0;
        3'd4: n.pre   = merge({16'd0, s.pre}, wd, b) & 32'h0000_FFFF;
        default: ;
      endcase
    end
    return n;
  endfunction

  task automatic cycle(input logic rst, input logic [31:0] a, input logic wr,
                       input logic rd, input logic [3:0] b, input logic [31:0] wd,
                       input bit use_const, input logic [31:0] cexp, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; memaddr = a; memwrite = wr; memread = rd; be = b; writedata = wd;
    e.rd   = use_const ? cexp : model_read(m, a, rd);
    e.nirq = m.nirq;
    e.tag  = tag;
    q.push_back(e);
    m = model_step(m, rst, a, wr, b, wd);
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d, input logic [3:0] b);
    cycle(1'b0, BASE + {27'd0, off}, 1'b1, 1'b0, b, d, 1'b0, 32'd0, "write");
  endtask

  task automatic rdc(input logic [31:0] a, input logic [31:0] exp, input string tag);
    cycle(1'b0, a, 1'b0, 1'b1, 4'd0, 32'd0, 1'b1, exp, tag);
  endtask

  task automatic rdm(input logic [4:0] off, input string tag);
    cycle(1'b0, BASE + {27'd0, off}, 1'b0, 1'b1, 4'd0, 32'd0, 1'b0, 32'd0, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, "idle");
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b1, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, "reset");
  endtask

  // Monitor: each cycle the DUT presents readdata and nIRQ; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (readdata !== e.rd) begin
          n_bad++;
          $display("FAIL %s readdata: got %08h expected %08h at %0t", e.tag, readdata, e.rd, $time);
        end
        n_cmp++;
        if (nIRQ !== e.nirq) begin
          n_bad++;
          $display("FAIL %s nIRQ: got %b expected %b at %0t", e.tag, nIRQ, e.nirq, $time);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  b;
    logic        rs, w, r;
    m = model_reset();

    // Reset and idle window
    rst_cycles(2);
    for (int i = 0; i < 8; i++) rdc(BASE + 32'(i * 4), 32'd0, "idle_reg");
    rdc(32'h0000_1000, 32'd0, "outside_low");
    rdc(BASE + 32'h20, 32'd0, "outside_above");

    // One-shot: expiry on the 4th edge after the CTRL write
    wr(5'h04, 32'd3, 4'hF);
    wr(5'h08, 32'd3, 4'hF);
    wr(5'h10, 32'd0, 4'hF);
    wr(5'h00, 32'h5, 4'hF);
    idle(6);
    rdc(BASE + 32'h00, 32'h4, "oneshot_ctrl");
    rdc(BASE + 32'h08, 32'h0, "oneshot_count");
    rdc(BASE + 32'h0C, 32'h1, "oneshot_pend");
    wr(5'h0C, 32'h1, 4'h1);
    idle(3);

    // Auto-reload with prescale, W1C between expiries
    wr(5'h04, 32'd1, 4'hF);
    wr(5'h08, 32'd1, 4'hF);
    wr(5'h10, 32'd2, 4'hF);
    wr(5'h00, 32'h7, 4'hF);
    idle(14);
    wr(5'h0C, 32'h1, 4'hF);
    idle(10);
    rdm(5'h0C, "auto_status");
    wr(5'h00, 32'h0, 4'hF);
    wr(5'h0C, 32'h1, 4'hF);

    // Byte enables
    wr(5'h04, 32'hAABB_CCDD, 4'hF);
    wr(5'h04, 32'h1122_3344, 4'b0101);
    rdc(BASE + 32'h04, 32'hAA22_CC44, "be_load");
    wr(5'h04, 32'hFFFF_FFFF, 4'b0000);
    rdc(BASE + 32'h04, 32'hAA22_CC44, "be_zero");

    // W1C in the same cycle as expiry keeps PEND
    wr(5'h04, 32'd5, 4'hF);
    wr(5'h10, 32'd0, 4'hF);
    wr(5'h08, 32'd2, 4'hF);
    wr(5'h00, 32'h7, 4'hF);
    idle(2);
    wr(5'h0C, 32'h1, 4'h1);
    rdc(BASE + 32'h0C, 32'h1, "w1c_vs_expiry");

    // COUNT write on a tick wins, then decrements next tick
    wr(5'h08, 32'h10, 4'hF);
    rdc(BASE + 32'h08, 32'h10, "count_wr_tick");
    rdc(BASE + 32'h08, 32'h0F, "count_after");

    // Mid-operation reset
    wr(5'h00, 32'h0, 4'hF);
    wr(5'h0C, 32'h1, 4'hF);
    wr(5'h08, 32'd8, 4'hF);
    wr(5'h00, 32'h5, 4'hF);
    idle(3);
    rdm(5'h08, "pre_reset_count");
    rst_cycles(1);
    for (int i = 0; i < 8; i++) rdc(BASE + 32'(i * 4), 32'd0, "post_reset");
    idle(20);
    rdc(BASE + 32'h0C, 32'd0, "no_expiry_after_reset");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) != 0) a = BASE + {27'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
      else a = $urandom;
      w = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 1);
      b = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      d = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 7)) : $urandom;
      cycle(rs, a, w, r, b, d, 1'b0, 32'd0, "random");
    end
    idle(2);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
